// File: rtl/ifu_prefetch.sv
// ----------------------------------------------------------------------------
// ifu_prefetch
//
// Instruction-fetch front end: a sequential fetch-PC generator, a read port to
// an instruction ROM with one cycle of latency, and a QDEPTH-entry prefetch
// queue that decode drains through a valid/ready handshake. An EX-stage
// redirect flushes every piece of speculative state and restarts fetch at the
// target address.
//
// Optional feature (compile-time macro IFU_BYPASS_EN):
//   When defined, a response that arrives while the queue is empty is shown on
//   out_* in the same cycle it arrives. If decode takes it in that cycle it
//   is never written into the queue. Without the macro every response goes
//   through the queue.
//
// Parameters:
//   ADDR_W    address / PC width
//   RESET_PC  fetch address after reset (word aligned)
//   QDEPTH    prefetch queue entries (power of two, >= 2)
//
// Ports:
//   clk             clock, all state on the rising edge
//   rst_n           asynchronous active-low reset
//   imem_req        read request to the ROM this cycle
//   imem_addr       word-aligned read address (meaningful when imem_req=1)
//   imem_rdata      ROM data, valid one cycle after an issued request
//   redirect_valid  EX-stage redirect (taken branch / jal / jalr)
//   redirect_pc     redirect target, bits [1:0] are dropped
//   out_valid       queue head holds an instruction
//   out_ready       decode takes the head this cycle
//   out_inst        head instruction (0 when out_valid=0)
//   out_pc          head instruction address (0 when out_valid=0)
//   out_pc4         out_pc + 4, the link value for jal/jalr
//   q_count         current queue occupancy
//
// Handshake: an instruction moves to decode on a rising edge where
// out_valid && out_ready are both high. out_valid never depends on
// out_ready, and out_* hold steady while out_valid=1 and out_ready=0.
// ----------------------------------------------------------------------------
module ifu_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       QDEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_inst,
  output logic [ADDR_W-1:0]             out_pc,
  output logic [ADDR_W-1:0]             out_pc4,
  output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [CW:0] QDEPTH_OCC = (CW + 1)'(QDEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic [31:0]       q_inst [QDEPTH];
  logic [ADDR_W-1:0] q_pc   [QDEPTH];

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic [CW:0] occupancy;    // entries held plus the one response in flight
  logic        rsp_live;     // a response is arriving and is not flushed
  logic        bypass_hit;   // the arriving response is shown directly on out_*
  logic        bypass_take;  // ... and decode takes it this cycle
  logic        push;         // write the arriving response into the queue
  logic        pop_q;        // retire the queue head

  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  // The inflight response is counted as a reserved slot, so a response can
  // always be written when it lands. This is the only overflow protection.
  // rst_n is folded in so the request drops as soon as reset is asserted.
  assign imem_req  = rst_n && !redirect_valid && (occupancy < QDEPTH_OCC);
  assign imem_addr = fetch_pc;

  // A response that lands in a redirect cycle belongs to the old stream.
  // No request goes out in a redirect cycle, so nothing from the old stream
  // can land in the cycle after it.
  assign rsp_live = inflight && !redirect_valid;

`ifdef IFU_BYPASS_EN
  assign bypass_hit = rsp_live && (count == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid   = !redirect_valid && ((count != '0) || bypass_hit);
  assign bypass_take = bypass_hit && out_ready;
  assign push        = rsp_live && !bypass_take;
  // When bypassing the queue is empty, so a handshake then never retires a
  // queue entry.
  assign pop_q       = out_valid && out_ready && !bypass_hit;

  // --------------------------------------------------------------------------
  // Output mux: the bypass path or the queue head, and zeros when idle.
  // --------------------------------------------------------------------------
  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (out_valid) begin
      if (bypass_hit) begin
        out_inst = imem_rdata;
        out_pc   = inflight_pc;
      end else begin
        out_inst = q_inst[rd_ptr];
        out_pc   = q_pc[rd_ptr];
      end
    end
  end

  assign out_pc4 = out_pc + ADDR_W'(4);
  assign q_count = count;

  // --------------------------------------------------------------------------
  // Fetch PC, inflight tracking, pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      // Redirect flushes the queue and drops any response still due.
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc    <= fetch_pc + ADDR_W'(4);
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_q) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop_q);
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage. Contents are never read before they are written, because
  // out_valid is gated by count, so the storage has no reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_prefetch
//
// Bench for ifu_prefetch (ADDR_W=32, RESET_PC=0x100, QDEPTH=4).
// The reference model is the instruction stream itself: after reset or a
// redirect, decode must see consecutive word addresses starting at the new
// PC, and each instruction must equal the ROM word for its address. The
// driver pushes that stream into exp_q when it resets or redirects. A monitor
// pops exp_q at every handshake and compares. Directed checks at fixed cycles
// cover reset values, latency, backpressure, redirect and wrap-around.
// ----------------------------------------------------------------------------
module tb_ifu_prefetch;

  localparam int unsigned QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef IFU_BYPASS_EN
  localparam logic        BYP = 1'b1;
`else
  localparam logic        BYP = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [2:0]  q_count;

  ifu_prefetch #(
    .ADDR_W  (32),
    .RESET_PC(RESET_PC),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_pc4       (out_pc4),
    .q_count       (q_count)
  );

  // --------------------------------------------------------------------------
  // Instruction ROM model: one cycle read latency, garbage when idle
  // --------------------------------------------------------------------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) ^ 32'hA5A5_5A5A;
  endfunction

  int unsigned cyc = 0;
  logic        inflight_tb = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req) imem_rdata <= rom_word(imem_addr);
    else          imem_rdata <= 32'hBAD0_0000 ^ cyc;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_tb <= 1'b0;
    else        inflight_tb <= imem_req;
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int          total = 0;
  int          bad = 0;
  int          hs_count = 0;
  int          occ;
  logic [31:0] exp_q[$];
  logic [31:0] next_tail;
  logic [31:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_tail);
      next_tail = next_tail + 32'd4;
    end
  endtask

  task automatic new_stream(input logic [31:0] start);
    exp_q.delete();
    next_tail = start & ~32'd3;
    refill();
  endtask

  // Monitor: credit check every cycle, and a stream check at every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      occ = int'(q_count) + int'(inflight_tb);
      total++;
      if (occ > int'(QDEPTH) || (imem_req && occ >= int'(QDEPTH))) begin
        bad++;
        $display("FAIL credit: q_count=%0d inflight=%0b imem_req=%0b, need occupancy<=%0d and no request at the limit",
                 q_count, inflight_tb, imem_req, QDEPTH);
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got pc %h with no expected entry", out_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          refill();
          chk("out_pc", out_pc, exp_pc);
          chk("out_inst", out_inst, rom_word(exp_pc));
          chk("out_pc4", out_pc4, exp_pc + 32'd4);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks reset values at once, and returns at the
  // start of cycle 0 after release.
  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    new_stream(RESET_PC);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc4", out_pc4, 32'd4);
    chk("rst_q_count", {29'd0, q_count}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    new_stream(target);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int hs_before;

  initial begin
    // Reset release and first-fetch latency, streaming at full rate
    out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("c0_imem_req", {31'd0, imem_req}, 32'd1);
    chk("c0_imem_addr", imem_addr, RESET_PC);
    tick(); @(negedge clk);
    chk("c1_out_valid", {31'd0, out_valid}, {31'd0, BYP});
    tick(); @(negedge clk);
    chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_out_pc", out_pc, BYP ? 32'h104 : 32'h100);
    for (int i = 0; i < 8; i++) begin
      tick(); @(negedge clk);
      chk("steady_valid", {31'd0, out_valid}, 32'd1);
    end

    // Backpressure: fill, single pop, exactly one refill request
    out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    @(negedge clk);
    chk("bp_full_count", {29'd0, q_count}, QDEPTH);
    chk("bp_full_req", {31'd0, imem_req}, 32'd0);
    chk("bp_head_pc", out_pc, 32'h100);
    tick(); out_ready = 1'b1;
    @(negedge clk);
    tick(); out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_pop_req", {31'd0, imem_req}, 32'd1);
    chk("bp_after_pop_count", {29'd0, q_count}, 32'd3);
    chk("bp_after_pop_head", out_pc, 32'h104);
    tick(); @(negedge clk);
    chk("bp_one_req_only", {31'd0, imem_req}, 32'd0);
    tick(); @(negedge clk);
    chk("bp_refull_count", {29'd0, q_count}, QDEPTH);
    tick(); out_ready = 1'b1;
    repeat (8) tick();

    // Redirect with 3 queued entries and one response in flight
    out_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    redirect(32'h0000_2002);
    @(negedge clk);
    chk("rd_pre_count", {29'd0, q_count}, 32'd3);
    chk("rd_cycle_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_cycle_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rd_r1_count", {29'd0, q_count}, 32'd0);
    chk("rd_r1_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_r1_req", {31'd0, imem_req}, 32'd1);
    chk("rd_r1_addr", imem_addr, 32'h2000);
    tick(); @(negedge clk);
    chk("rd_r2_valid", {31'd0, out_valid}, {31'd0, BYP});
    tick(); @(negedge clk);
    chk("rd_r3_valid", {31'd0, out_valid}, 32'd1);
    chk("rd_r3_pc", out_pc, BYP ? 32'h2004 : 32'h2000);
    repeat (6) tick();

    // Back-to-back redirects: only the second stream may emerge
    redirect(32'h0000_0400);
    @(negedge clk);
    chk("b2b_r0_valid", {31'd0, out_valid}, 32'd0);
    tick(); redirect(32'h0000_0800);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("b2b_r2_valid", {31'd0, out_valid}, 32'd0);
    tick(); @(negedge clk);
    chk("b2b_r3_valid", {31'd0, out_valid}, {31'd0, BYP});
    tick(); @(negedge clk);
    chk("b2b_r4_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_r4_pc", out_pc, BYP ? 32'h804 : 32'h800);
    repeat (6) tick();

    // Address wrap-around at the top of the address space
    hs_before = hs_count;
    redirect(32'hFFFF_FFF8);
    tick(); redirect_valid = 1'b0;
    repeat (8) tick();
    chk("wrap_flow", (hs_count - hs_before >= 4) ? 32'd1 : 32'd0, 32'd1);

    // Randomized backpressure and redirects
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0) redirect($urandom());
      else redirect_valid = 1'b0;
      tick();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    // Reset while the queue holds a stale stream
    out_ready = 1'b0;
    redirect(32'h0000_3000);
    tick(); redirect_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("stale_pre_count", {29'd0, q_count}, 32'd3);
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    repeat (10) tick();

    chk("handshakes_seen", (hs_count >= 100) ? 32'd1 : 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit for the pipelined core. It replaces the single-cycle PC/next-PC pair with three parts: a sequential fetch-PC generator, a one-cycle-latency instruction-memory request port, and a QDEPTH-entry prefetch queue. Decode consumes instructions through a valid/ready handshake. The execute stage redirects fetch on taken branches and jumps, which flushes all speculative state.

## Interface
- ADDR_W, 32: address/PC width; PC increments by 4 modulo 2^ADDR_W.
- RESET_PC, {ADDR_W{1'b0}}: fetch address after reset; bits [1:0] must be 0.
- QDEPTH, 4: prefetch queue entries; power of two, ≥2.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  read request to IROM this cycle.
- imem_addr  output  ADDR_W  word-aligned read address, valid when imem_req=1.
- imem_rdata  input  32  instruction, valid exactly one cycle after an accepted imem_req.
- redirect_valid  input  1  EX-stage redirect (taken branch/jal/jalr).
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced to 00).
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_inst  output  32  head instruction.
- out_pc  output  ADDR_W  head instruction address.
- out_pc4  output  ADDR_W  out_pc+4 (link value for jal/jalr).
- q_count  output  $clog2(QDEPTH+1)  current queue occupancy.

## Operation
- State: fetch_pc; inflight flag with tag register inflight_pc; circular queue (inst, pc) with rd_ptr/wr_ptr mod QDEPTH; count.
- Issue: imem_req=1 iff !redirect_valid and (count+inflight) < QDEPTH. imem_addr=fetch_pc. On issue, fetch_pc<=fetch_pc+4, inflight<=1, inflight_pc<=fetch_pc; otherwise inflight<=0.
- Response: in the cycle after issue, {imem_rdata, inflight_pc} is pushed at wr_ptr unless killed.
- The credit rule (count+inflight) is the only overflow protection. A push into a full queue is impossible; a bench assertion checks this.
- Pop: on out_valid && out_ready, rd_ptr advances. A push and a pop in the same cycle leaves count unchanged.
- Redirect, with priority over everything except reset:
  - count<=0, rd_ptr<=wr_ptr<=0.
  - Any response arriving in that cycle or the next (an inflight issued before the redirect) is discarded.
  - fetch_pc<=redirect_pc&~3.
  - No request in the redirect cycle; the first request to the target goes out the following cycle.
- out_valid is forced to 0 during a redirect cycle, so no pop occurs.
- out_pc4=out_pc+4 mod 2^ADDR_W; fetch_pc wraps 0xFFFF_FFFC→0x0000_0000 (ADDR_W=32) without error.
- Reset (asynchronous, any time, including mid-transfer):
  - fetch_pc=RESET_PC, inflight=0, pointers/count=0.
  - out_valid=0, out_inst=0, out_pc=0, out_pc4=4, q_count=0, imem_req=0.
  - A response after reset deassertion from a pre-reset request is ignored.

## Timing
- Cycle 0 after reset release: imem_req=1, imem_addr=RESET_PC.
- Request→out_valid latency: 2 cycles (rdata in cycle N+1, written; visible in N+2).
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs.
- Redirect in cycle R: req to target in R+1, target instruction out_valid in R+3.
- out_ready low: queue fills to QDEPTH, then imem_req deasserts. It reasserts the cycle after the pop that frees a slot.

## Configuration
- IFU_BYPASS_EN defined: when count==0 and a non-killed response arrives, out_valid=1 combinationally in that same cycle, with out_inst=imem_rdata and out_pc=inflight_pc.
  - If out_ready=1, the entry is consumed and not written.
  - Request→out_valid latency becomes 1; redirect-to-target becomes R+2.
- Undefined: all responses go through the queue; latencies as in Timing.

## Test plan
- Reset release with RESET_PC=0x100, IROM word i at 0x100+4i, out_ready=1 → out_pc sequence 0x100, 0x104, 0x108… one per cycle from cycle 2 (cycle 1 with IFU_BYPASS_EN); out_pc4=out_pc+4.
- Backpressure, QDEPTH=4, out_ready=0 → q_count reaches 4, imem_req low. Raise out_ready for one cycle → one pop of 0x100 and exactly one new request. No lost or duplicated PCs.
- Redirect to 0x2002 while queue holds 3 entries and one request is inflight:
  - q_count=0 and out_valid=0 next cycle.
  - Next imem_addr=0x2000.
  - Inflight response never appears on out_*.
- Back-to-back redirects in cycles R and R+1 (0x400, then 0x800) → only 0x800 stream emerges, first at R+4 (R+3 with bypass).
- Wrap: redirect to 0xFFFF_FFF8 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc4 of 0xFFFF_FFFC is 0.
- Assert rst_n low while queue full and request inflight:
  - All outputs immediately at reset values.
  - After release, first imem_addr=RESET_PC and no stale instruction on out_*.
